// File: rtl/audio_dac_scheduler.sv
// audio_dac_scheduler: mixes two stereo sources once per sample period and drives an
// offset-binary DAC with pop-free mute ramps. Define AUDIO_DAC_SCHED_SATURATE_EN to
// saturate overflowing sums; otherwise they wrap. clip pulses on overflow either way.
module audio_dac_scheduler #(
    parameter int SIGNALWIDTH = 16,
    parameter int RATEDIV     = 1024,
    parameter int RAMPSTEP    = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   fm_valid,
    output logic                   fm_ready,
    input  logic [SIGNALWIDTH-1:0] fm_l,
    input  logic [SIGNALWIDTH-1:0] fm_r,
    input  logic                   psg_valid,
    output logic                   psg_ready,
    input  logic [SIGNALWIDTH-1:0] psg_l,
    input  logic [SIGNALWIDTH-1:0] psg_r,
    input  logic                   mute,
    output logic                   sample_tick,
    output logic [SIGNALWIDTH-1:0] dac_l,
    output logic [SIGNALWIDTH-1:0] dac_r,
    output logic                   clip,
    output logic [1:0]             state
);
    localparam int W  = SIGNALWIDTH;
    localparam int CW = $clog2(RATEDIV);
    localparam logic [1:0] MUTED = 2'd0, RAMP_UP = 2'd1, RUN = 2'd2, RAMP_DOWN = 2'd3;
    localparam logic [W-1:0] STEP = W'(RAMPSTEP);

    logic [CW-1:0] cnt;
    logic          fm_full, psg_full;
    logic [W-1:0]  fm_buf_l, fm_buf_r, psg_buf_l, psg_buf_r;
    logic [W-1:0]  fm_cur_l, fm_cur_r, psg_cur_l, psg_cur_r;
    logic          tick_d1, tick_d2, mute_s;
    logic [W:0]    sum_l, sum_r;
    logic          ovf_l, ovf_r;
    logic [W-1:0]  red_l, red_r, tgt_l, tgt_r;
    logic [W-1:0]  up_l, up_r, down_l, down_r;
    logic [W-1:0]  dac_l_nxt, dac_r_nxt;
    logic [1:0]    state_nxt;
    logic          going_down;

    function automatic logic [W-1:0] ramp_up(input logic [W-1:0] d, input logic [W-1:0] t);
        return (d < t) ? ((t - d <= STEP) ? t : d + STEP)
                       : ((d - t <= STEP) ? t : d - STEP);
    endfunction

    function automatic logic [W-1:0] ramp_down(input logic [W-1:0] d);
        return (d > STEP) ? d - STEP : '0;
    endfunction

    assign sample_tick = (cnt == CW'(RATEDIV - 1));
    assign fm_ready    = !fm_full;
    assign psg_ready   = !psg_full;

    // Period counter wrapping at RATEDIV-1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else          cnt <= sample_tick ? '0 : cnt + 1'b1;
    end

    // Holding buffers: accept when empty, hand over to current sample on tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fm_full   <= 1'b0;
            psg_full  <= 1'b0;
            fm_buf_l  <= '0;
            fm_buf_r  <= '0;
            psg_buf_l <= '0;
            psg_buf_r <= '0;
            fm_cur_l  <= '0;
            fm_cur_r  <= '0;
            psg_cur_l <= '0;
            psg_cur_r <= '0;
        end else begin
            fm_full  <= (fm_valid && !fm_full) || (fm_full && !sample_tick);
            psg_full <= (psg_valid && !psg_full) || (psg_full && !sample_tick);
            if (fm_valid && !fm_full) begin
                fm_buf_l <= fm_l;
                fm_buf_r <= fm_r;
            end
            if (psg_valid && !psg_full) begin
                psg_buf_l <= psg_l;
                psg_buf_r <= psg_r;
            end
            if (sample_tick && fm_full) begin
                fm_cur_l <= fm_buf_l;
                fm_cur_r <= fm_buf_r;
            end
            if (sample_tick && psg_full) begin
                psg_cur_l <= psg_buf_l;
                psg_cur_r <= psg_buf_r;
            end
        end
    end

    // Tick pipeline, mute sampling and one-cycle-late mix register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_d1 <= 1'b0;
            tick_d2 <= 1'b0;
            mute_s  <= 1'b1;
            sum_l   <= '0;
            sum_r   <= '0;
        end else begin
            tick_d1 <= sample_tick;
            tick_d2 <= tick_d1;
            if (sample_tick) mute_s <= mute;
            if (tick_d1) begin
                sum_l <= {fm_cur_l[W-1], fm_cur_l} + {psg_cur_l[W-1], psg_cur_l};
                sum_r <= {fm_cur_r[W-1], fm_cur_r} + {psg_cur_r[W-1], psg_cur_r};
            end
        end
    end

    assign ovf_l = sum_l[W] ^ sum_l[W-1];
    assign ovf_r = sum_r[W] ^ sum_r[W-1];
`ifdef AUDIO_DAC_SCHED_SATURATE_EN
    assign red_l = ovf_l ? {sum_l[W], {(W-1){~sum_l[W]}}} : sum_l[W-1:0];
    assign red_r = ovf_r ? {sum_r[W], {(W-1){~sum_r[W]}}} : sum_r[W-1:0];
`else
    assign red_l = sum_l[W-1:0];
    assign red_r = sum_r[W-1:0];
`endif
    assign tgt_l      = {~red_l[W-1], red_l[W-2:0]};
    assign tgt_r      = {~red_r[W-1], red_r[W-2:0]};
    assign up_l       = ramp_up(dac_l, tgt_l);
    assign up_r       = ramp_up(dac_r, tgt_r);
    assign down_l     = ramp_down(dac_l);
    assign down_r     = ramp_down(dac_r);
    assign going_down = mute_s && state != MUTED;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= MUTED;
        else          state <= state_nxt;
    end

    // Next state: decided once per period at the dac update slot
    always_comb begin
        state_nxt = state;
        if (tick_d2)
            state_nxt = (state == MUTED) ? (mute_s ? MUTED : RAMP_UP) :
                        going_down       ? ((down_l == '0 && down_r == '0) ? MUTED : RAMP_DOWN) :
                        (state == RUN)   ? RUN :
                        ((up_l == tgt_l && up_r == tgt_r) ? RUN : RAMP_UP);
    end

    // Output: dac value for the mode being entered; muted start holds at zero
    always_comb begin
        dac_l_nxt = (state == MUTED) ? '0 : going_down ? down_l : (state == RUN) ? tgt_l : up_l;
        dac_r_nxt = (state == MUTED) ? '0 : going_down ? down_r : (state == RUN) ? tgt_r : up_r;
    end

    // DAC and clip registers updated two cycles after the tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dac_l <= '0;
            dac_r <= '0;
            clip  <= 1'b0;
        end else begin
            clip <= tick_d2 && (ovf_l || ovf_r);
            if (tick_d2) begin
                dac_l <= dac_l_nxt;
                dac_r <= dac_r_nxt;
            end
        end
    end
endmodule

// File: tb/tb_audio_dac_scheduler.sv
// tb_audio_dac_scheduler: directed checks of ramping, mixing, clipping, handshake and reset.
module tb_audio_dac_scheduler;
    localparam int RD = 16;

    logic        clk = 0, reset_n = 1;
    logic        fm_valid = 0, psg_valid = 0, mute = 0;
    logic [15:0] fm_l = 0, fm_r = 0, psg_l = 0, psg_r = 0;
    logic        fm_ready, psg_ready, sample_tick, clip;
    logic [15:0] dac_l, dac_r;
    logic [1:0]  state;
    int          checks = 0, fails = 0;

    audio_dac_scheduler #(.SIGNALWIDTH(16), .RATEDIV(RD), .RAMPSTEP(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .fm_valid(fm_valid), .fm_ready(fm_ready), .fm_l(fm_l), .fm_r(fm_r),
        .psg_valid(psg_valid), .psg_ready(psg_ready), .psg_l(psg_l), .psg_r(psg_r),
        .mute(mute), .sample_tick(sample_tick),
        .dac_l(dac_l), .dac_r(dac_r), .clip(clip), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        bit found = 0;
        for (int i = 0; i < RD + 2 && !found; i++) begin
            step();
            found = sample_tick;
        end
        checks++;
        assert (found) else begin
            fails++;
            $error("FAIL tick_timeout: got no tick expected tick within %0d cycles", RD + 2);
        end
    endtask

    task automatic period();
        wait_tick();
        step();
        step();
        step();
    endtask

    task automatic send_fm(input logic [15:0] l, input logic [15:0] r);
        fm_l = l; fm_r = r; fm_valid = 1;
        step();
        fm_valid = 0;
    endtask

    task automatic send_psg(input logic [15:0] l, input logic [15:0] r);
        psg_l = l; psg_r = r; psg_valid = 1;
        step();
        psg_valid = 0;
    endtask

    initial begin
        logic [15:0] e_l, e_r, acc, held;
        int          rdy_cnt, wait_cnt, ticks;
        bit          clip_seen;

        #2 reset_n = 0;
        #1;
        chk("rst_dac_l", dac_l, 16'h0000);
        chk("rst_dac_r", dac_r, 16'h0000);
        chk("rst_state", state, 2'd0);
        chk("rst_fm_ready", fm_ready, 1);
        chk("rst_psg_ready", psg_ready, 1);
        chk("rst_tick", sample_tick, 0);
        chk("rst_clip", clip, 0);
        step();
        step();
        reset_n = 1;

        // pop-free start ramp from zero up to mid-scale
        period();
        chk("start_state", state, 2'd1);
        chk("start_dac", dac_l, 16'h0000);
        clip_seen = 0;
        for (int k = 2; k <= 513; k++) begin
            period();
            clip_seen |= clip;
            if (k == 2) chk("ramp_first_step", dac_l, 16'h0040);
            if (k == 3) chk("ramp_second_step", dac_r, 16'h0080);
            if (k == 512) chk("ramp_before_end_state", state, 2'd1);
        end
        chk("ramp_end_dac_l", dac_l, 16'h8000);
        chk("ramp_end_dac_r", dac_r, 16'h8000);
        chk("ramp_end_state", state, 2'd2);
        chk("ramp_no_clip", clip_seen, 0);

        // overflow in both directions
        fm_valid = 1; psg_valid = 1;
        fm_l = 16'h7000; fm_r = 16'h8000; psg_l = 16'h2000; psg_r = 16'h8000;
        step();
        fm_valid = 0; psg_valid = 0;
`ifdef AUDIO_DAC_SCHED_SATURATE_EN
        e_l = 16'hFFFF; e_r = 16'h0000;
`else
        e_l = 16'h1000; e_r = 16'h8000;
`endif
        period();
        chk("ovf_dac_l", dac_l, e_l);
        chk("ovf_dac_r", dac_r, e_r);
        chk("ovf_clip", clip, 1);
        chk("ovf_state", state, 2'd2);
        step();
        chk("ovf_clip_pulse", clip, 0);

        // fm streaming one sample per cycle: one accept per period
        send_psg(16'h0010, 16'h0020);
        fm_r = 0; fm_valid = 1;
        acc = 0; held = 0; rdy_cnt = 0; wait_cnt = 0; ticks = 0;
        for (int c = 0; c < 3 * RD + 4; c++) begin
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    chk("stream_dac_l", dac_l, 16'h8000 + held + 16'h0010);
                    chk("stream_dac_r", dac_r, 16'h8020);
                end
            end
            fm_l = 16'h0100 + 16'(c * 16);
            if (sample_tick) begin
                chk("stream_ready_per_period", rdy_cnt, 1);
                held = acc; rdy_cnt = 0; wait_cnt = 3; ticks++;
            end
            if (fm_ready) begin
                acc = fm_l;
                rdy_cnt++;
            end
            step();
        end
        fm_valid = 0;
        chk("stream_ticks", ticks >= 3, 1);

        // psg idle: last psg sample reused, fm change lands two cycles after tick
        period();
        chk("drain_dac_l", dac_l, 16'h8000 + acc + 16'h0010);
        send_fm(16'h1234, 16'h0100);
        wait_tick();
        step();
        step();
        chk("latency_old_dac_l", dac_l, 16'h8000 + acc + 16'h0010);
        step();
        chk("hold_psg_dac_l", dac_l, 16'h9244);
        chk("hold_psg_dac_r", dac_r, 16'h8120);
        send_fm(16'hFF00, 16'h0000);
        period();
        chk("neg_dac_l", dac_l, 16'h7F10);
        chk("neg_dac_r", dac_r, 16'h8020);

        // back to mid-scale, mute glitch between ticks is ignored
        send_fm(16'h0000, 16'h0000);
        send_psg(16'h0000, 16'h0000);
        period();
        chk("mid_dac_l", dac_l, 16'h8000);
        mute = 1;
        step(); step(); step();
        mute = 0;
        period();
        chk("glitch_state", state, 2'd2);
        chk("glitch_dac_l", dac_l, 16'h8000);

        // mute for 100 periods then release
        mute = 1;
        clip_seen = 0;
        for (int k = 1; k <= 100; k++) begin
            period();
            clip_seen |= clip;
            chk("down_dac_l", dac_l, 16'h8000 - 16'(64 * k));
            chk("down_state", state, 2'd3);
        end
        chk("down_end_dac_r", dac_r, 16'h6700);
        mute = 0;
        for (int k = 1; k <= 100; k++) begin
            period();
            clip_seen |= clip;
            chk("up_dac_l", dac_l, 16'h6700 + 16'(64 * k));
            chk("up_state", state, (k == 100) ? 2'd2 : 2'd1);
        end
        chk("updown_dac_r", dac_r, 16'h8000);
        chk("updown_no_clip", clip_seen, 0);

        // reset mid ramp-down with fm buffer full
        mute = 1;
        period(); period(); period();
        chk("pre_rst_dac_l", dac_l, 16'h7F40);
        chk("pre_rst_state", state, 2'd3);
        send_fm(16'h4000, 16'h4000);
        chk("pre_rst_fm_full", fm_ready, 0);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_dac_l", dac_l, 16'h0000);
        chk("mid_rst_dac_r", dac_r, 16'h0000);
        chk("mid_rst_state", state, 2'd0);
        chk("mid_rst_fm_ready", fm_ready, 1);
        step();
        mute = 0;
        reset_n = 1;
        period();
        chk("restart_state", state, 2'd1);
        chk("restart_dac", dac_l, 16'h0000);
        period();
        chk("restart_step", dac_l, 16'h0040);
        chk("restart_fm_ready", fm_ready, 1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
